// File: rtl/csr_trap_sequencer.sv
// Sequences CSR-file accesses for trap entry (mepc, mcause, mtvec) and mret,
// and passes single-cycle instruction CSR accesses through while idle.
// CSR access encoding: 2'b00 read-only, 2'b01 write, 2'b10 set, 2'b11 clear.
module csr_trap_sequencer #(
   parameter logic [11:0] MEPC_ADDR   = 12'h341,
   parameter logic [11:0] MCAUSE_ADDR = 12'h342,
   parameter logic [11:0] MTVEC_ADDR  = 12'h305
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [11:0] inst_number,
   input  logic [1:0]  inst_access_type,
   input  logic [31:0] inst_in,
   output logic        inst_ready,
   output logic [31:0] inst_rdata,
   input  logic        trap_req,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   output logic        trap_ack,
   output logic [31:0] trap_target,
   input  logic        mret_req,
   output logic        mret_ack,
   output logic [31:0] mret_target,
   output logic [11:0] csr_number,
   output logic [1:0]  csr_access_type,
   output logic [31:0] csr_in,
   input  logic [31:0] csr_out,
   output logic        busy
);

   localparam logic [1:0] CSR_READ_ONLY = 2'b00;
   localparam logic [1:0] CSR_WRITE     = 2'b01;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      T_EPC   = 3'd1,
      T_CAUSE = 3'd2,
      T_VEC   = 3'd3,
      M_EPC   = 3'd4
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] cause_reg, cause_next;
   logic [31:0] trap_target_reg, trap_target_next;
   logic [31:0] mret_target_reg, mret_target_next;
   logic [31:0] vec_base;
   logic [31:0] vec_offset;

   assign vec_base   = {csr_out[31:2], 2'b00};
   assign vec_offset = {cause_reg[29:0], 2'b00};
   assign inst_rdata = csr_out;
   assign busy       = (state_reg != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         pc_reg          <= '0;
         cause_reg       <= '0;
         trap_target_reg <= '0;
         mret_target_reg <= '0;
      end else begin
         state_reg       <= state_next;
         pc_reg          <= pc_next;
         cause_reg       <= cause_next;
         trap_target_reg <= trap_target_next;
         mret_target_reg <= mret_target_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      pc_next          = pc_reg;
      cause_next       = cause_reg;
      trap_target_next = trap_target_reg;
      mret_target_next = mret_target_reg;
      csr_number       = inst_number;
      csr_access_type  = CSR_READ_ONLY;
      csr_in           = '0;
      inst_ready       = 1'b0;
      trap_ack         = 1'b0;
      mret_ack         = 1'b0;

      case (state_reg)
         IDLE: begin
            if (trap_req) begin
               pc_next    = trap_pc;
               cause_next = trap_cause;
               state_next = T_EPC;
            end else if (mret_req) begin
               state_next = M_EPC;
            end else if (inst_req) begin
               csr_access_type = inst_access_type;
               csr_in          = inst_in;
               inst_ready      = 1'b1;
            end
         end
         T_EPC: begin
            csr_number      = MEPC_ADDR;
            csr_access_type = CSR_WRITE;
            csr_in          = pc_reg;
            state_next      = T_CAUSE;
         end
         T_CAUSE: begin
            csr_number      = MCAUSE_ADDR;
            csr_access_type = CSR_WRITE;
            csr_in          = cause_reg;
            state_next      = T_VEC;
         end
         T_VEC: begin
            csr_number = MTVEC_ADDR;
            // Vectored mode only offsets asynchronous interrupts; exceptions use the base.
            if (csr_out[1:0] == 2'b01 && cause_reg[31])
               trap_target_next = vec_base + vec_offset;
            else
               trap_target_next = vec_base;
            trap_ack   = 1'b1;
            state_next = IDLE;
         end
         M_EPC: begin
            csr_number       = MEPC_ADDR;
            mret_target_next = vec_base;
            mret_ack         = 1'b1;
            state_next       = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Targets are visible in the ack cycle itself, then held by the register.
      trap_target = (state_reg == T_VEC) ? trap_target_next : trap_target_reg;
      mret_target = (state_reg == M_EPC) ? mret_target_next : mret_target_reg;

      if (reset) begin
         inst_ready      = 1'b0;
         csr_access_type = CSR_READ_ONLY;
      end
   end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Scoreboard bench for csr_trap_sequencer with a behavioural CSR file attached.
module tb_csr_trap_sequencer;

   localparam logic [11:0] MEPC_A   = 12'h341;
   localparam logic [11:0] MCAUSE_A = 12'h342;
   localparam logic [11:0] MTVEC_A  = 12'h305;
   localparam logic [1:0]  RD = 2'b00, WR = 2'b01, ST = 2'b10, CL = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [11:0] inst_number;
   logic [1:0]  inst_access_type;
   logic [31:0] inst_in;
   logic        inst_ready;
   logic [31:0] inst_rdata;
   logic        trap_req;
   logic [31:0] trap_pc;
   logic [31:0] trap_cause;
   logic        trap_ack;
   logic [31:0] trap_target;
   logic        mret_req;
   logic        mret_ack;
   logic [31:0] mret_target;
   logic [11:0] csr_number;
   logic [1:0]  csr_access_type;
   logic [31:0] csr_in;
   logic [31:0] csr_out;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t inst_q[$];
   exp_t trap_q[$];
   exp_t mret_q[$];

   logic [31:0] csr_mem [4096] = '{default: '0};

   csr_trap_sequencer dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_number(inst_number), .inst_access_type(inst_access_type),
      .inst_in(inst_in), .inst_ready(inst_ready), .inst_rdata(inst_rdata),
      .trap_req(trap_req), .trap_pc(trap_pc), .trap_cause(trap_cause),
      .trap_ack(trap_ack), .trap_target(trap_target),
      .mret_req(mret_req), .mret_ack(mret_ack), .mret_target(mret_target),
      .csr_number(csr_number), .csr_access_type(csr_access_type), .csr_in(csr_in),
      .csr_out(csr_out), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // External CSR file: combinational read, update on the clock edge
   assign csr_out = csr_mem[csr_number];
   always @(posedge clk) begin
      case (csr_access_type)
         WR: csr_mem[csr_number] <= csr_in;
         ST: csr_mem[csr_number] <= csr_mem[csr_number] | csr_in;
         CL: csr_mem[csr_number] <= csr_mem[csr_number] & ~csr_in;
         default: ;
      endcase
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
      end else begin
         $display("ok   %s cyc=%0d value=%h", name, cyc, got);
      end
   endtask

   task automatic check_event(input string name, input exp_t e, input logic [31:0] got);
      total++;
      if (got !== e.data || cyc != e.cyc) begin
         bad++;
         $display("FAIL %s got=%h@cyc%0d exp=%h@cyc%0d", name, got, cyc, e.data, e.cyc);
      end else begin
         $display("ok   %s value=%h cyc=%0d", name, got, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT presents a response
   always @(negedge clk) begin
      if (trap_ack && mret_ack) check("ack_overlap", 64'd1, 64'd0);
      if (inst_ready) begin
         if (inst_q.size() == 0) check("inst_unexpected", 64'd1, 64'd0);
         else check_event("inst_rdata", inst_q.pop_front(), inst_rdata);
      end
      if (trap_ack) begin
         if (trap_q.size() == 0) check("trap_ack_unexpected", 64'd1, 64'd0);
         else check_event("trap_target", trap_q.pop_front(), trap_target);
      end
      if (mret_ack) begin
         if (mret_q.size() == 0) check("mret_ack_unexpected", 64'd1, 64'd0);
         else check_event("mret_target", mret_q.pop_front(), mret_target);
      end
   end

   function automatic logic pick(input int sel);
      case (sel)
         0: return trap_ack;
         1: return mret_ack;
         default: return inst_ready;
      endcase
   endfunction

   // Called at a negedge; waits (bounded) until the selected signal is high
   task automatic wait_for(input int sel, input string name);
      int n = 0;
      while (!pick(sel) && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (!pick(sel)) begin
         bad++;
         $display("FAIL %s_timeout got=0 exp=1", name);
      end
   endtask

   task automatic do_inst(input logic [11:0] num, input logic [1:0] typ,
                          input logic [31:0] din, input logic [31:0] exp_rdata);
      @(posedge clk); #1;
      inst_req = 1'b1; inst_number = num; inst_access_type = typ; inst_in = din;
      inst_q.push_back('{exp_rdata, cyc});
      @(negedge clk);
      wait_for(2, "inst_ready");
      @(posedge clk); #1;
      inst_req = 1'b0;
   endtask

   task automatic do_trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] target);
      @(posedge clk); #1;
      trap_req = 1'b1; trap_pc = pc; trap_cause = cause;
      trap_q.push_back('{target, cyc + 3});
      @(negedge clk);
      @(negedge clk);
      check("epc_write", {csr_number, csr_access_type, csr_in}, {MEPC_A, WR, pc});
      @(negedge clk);
      check("cause_write", {csr_number, csr_access_type, csr_in}, {MCAUSE_A, WR, cause});
      @(negedge clk);
      wait_for(0, "trap_ack");
      @(posedge clk); #1;
      trap_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      reset = 1'b1;
      trap_req = 1'b0; trap_pc = '0; trap_cause = '0; mret_req = 1'b0;
      inst_req = 1'b1; inst_number = MTVEC_A; inst_access_type = WR; inst_in = 32'h5555_5555;

      // Reset state, with an instruction write request pending
      @(negedge clk); @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_acks", {trap_ack, mret_ack}, 0);
      check("rst_targets", {trap_target, mret_target}, 0);
      check("rst_inst_ready", inst_ready, 0);
      check("rst_access_type", csr_access_type, RD);
      inst_req = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;

      // Instruction write then read-back of mtvec
      do_inst(MTVEC_A, WR, 32'h0000_1000, 32'h0);
      do_inst(MTVEC_A, RD, 32'h0, 32'h0000_1000);

      // Direct-mode trap
      do_trap(32'h80, 32'h2, 32'h0000_1000);
      do_inst(MEPC_A, RD, 32'h0, 32'h80);
      do_inst(MCAUSE_A, RD, 32'h0, 32'h2);

      // Vectored interrupt, then a synchronous exception under vectored mtvec
      do_inst(MTVEC_A, WR, 32'h0000_1001, 32'h0000_1000);
      do_trap(32'h90, 32'h8000_0007, 32'h0000_101C);
      do_trap(32'h94, 32'h3, 32'h0000_1000);
      check("trap_target_hold", trap_target, 32'h0000_1000);

      // mret with an instruction request waiting behind it; mepc low bits cleared
      do_inst(MEPC_A, WR, 32'h87, 32'h94);
      @(posedge clk); #1;
      mret_req = 1'b1; inst_req = 1'b1; inst_number = MCAUSE_A; inst_access_type = RD; inst_in = '0;
      c = cyc;
      mret_q.push_back('{32'h84, c + 1});
      inst_q.push_back('{32'h3, c + 2});
      @(negedge clk);
      check("mret_accept_inst_ready", inst_ready, 0);
      @(negedge clk);
      check("mret_busy_inst_ready", {busy, inst_ready}, {1'b1, 1'b0});
      wait_for(1, "mret_ack");
      @(posedge clk); #1;
      mret_req = 1'b0;
      @(negedge clk);
      wait_for(2, "inst_ready");
      @(posedge clk); #1;
      inst_req = 1'b0;

      // Simultaneous trap, mret and instruction requests
      @(posedge clk); #1;
      trap_req = 1'b1; trap_pc = 32'h200; trap_cause = 32'h8000_0003;
      mret_req = 1'b1;
      inst_req = 1'b1; inst_number = MTVEC_A; inst_access_type = RD;
      c = cyc;
      trap_q.push_back('{32'h0000_100C, c + 3});
      mret_q.push_back('{32'h200, c + 5});
      inst_q.push_back('{32'h0000_1001, c + 6});
      @(negedge clk);
      check("simul_inst_ready", inst_ready, 0);
      wait_for(0, "trap_ack");
      @(posedge clk); #1;
      trap_req = 1'b0;
      @(negedge clk);
      wait_for(1, "mret_ack");
      @(posedge clk); #1;
      mret_req = 1'b0;
      @(negedge clk);
      wait_for(2, "inst_ready");
      @(posedge clk); #1;
      inst_req = 1'b0;

      // Reset asserted during T_CAUSE aborts the sequence
      do_inst(MCAUSE_A, WR, 32'hDEAD_BEEF, 32'h8000_0003);
      @(posedge clk); #1;
      trap_req = 1'b1; trap_pc = 32'h300; trap_cause = 32'h5;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_abort_state", {busy, csr_number, csr_access_type}, {1'b1, MCAUSE_A, WR});
      #1;
      reset = 1'b1; trap_req = 1'b0;
      #1;
      check("abort_busy_ack", {busy, trap_ack}, 0);
      check("abort_access_type", csr_access_type, RD);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("post_reset_targets", {trap_target, mret_target}, 0);
      do_inst(MCAUSE_A, RD, 32'h0, 32'hDEAD_BEEF);
      do_inst(MEPC_A, RD, 32'h0, 32'h300);

      // Recovery trap after the abort
      do_trap(32'h400, 32'h8000_000B, 32'h0000_102C);

      repeat (3) @(negedge clk);
      check("inst_q_empty", inst_q.size(), 0);
      check("trap_q_empty", trap_q.size(), 0);
      check("mret_q_empty", mret_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
